// File: rtl/wb_arbiter.sv
// wb_arbiter: register-file writeback arbiter between a no-backpressure ALU and a
// load-result FIFO, with load data extension and a per-register pending-load scoreboard.
module wb_arbiter #(
  parameter int LSU_DEPTH = 2
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_alu_valid,
  input  logic [4:0]                   i_alu_rd,
  input  logic [31:0]                  i_alu_data,
  input  logic                         i_lsu_valid,
  output logic                         o_lsu_ready,
  input  logic [4:0]                   i_lsu_rd,
  input  logic [31:0]                  i_lsu_data,
  input  logic [2:0]                   i_lsu_funct3,
  input  logic [1:0]                   i_lsu_byteoff,
  input  logic                         i_ld_issue,
  input  logic [4:0]                   i_ld_issue_rd,
  output logic                         o_rd_wren,
  output logic [4:0]                   o_rd_addr,
  output logic [31:0]                  o_rd_data,
  output logic [31:0]                  o_pending,
  output logic [$clog2(LSU_DEPTH):0]   o_lsu_count
);
  localparam int AW = $clog2(LSU_DEPTH);
  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
    logic [2:0]  f3;
    logic [1:0]  off;
  } ent_t;
  ent_t mem [LSU_DEPTH];
  ent_t head;
  logic [AW-1:0] wptr, rptr;
  logic [AW:0] count;
  logic alu_req, push, pop;
  logic [7:0] bsel;
  logic [15:0] half;
  logic [31:0] ext, pend_nxt;
  assign o_lsu_count = count;
  assign o_lsu_ready = count < (AW+1)'(LSU_DEPTH);
  always_comb begin
    head = mem[rptr];
    alu_req = i_alu_valid && i_alu_rd != 5'd0;
    push = i_lsu_valid && o_lsu_ready && i_lsu_rd != 5'd0;
    pop = !alu_req && count != '0;
    bsel = 8'(head.data >> {head.off, 3'b000});
    half = head.off[1] ? head.data[31:16] : head.data[15:0];
    ext = head.f3 == 3'b000 ? {{24{bsel[7]}}, bsel} :
          head.f3 == 3'b001 ? {{16{half[15]}}, half} :
          head.f3 == 3'b100 ? {24'd0, bsel} :
          head.f3 == 3'b101 ? {16'd0, half} : head.data;
    pend_nxt = o_pending;
    if (pop) pend_nxt[head.rd] = 1'b0;
    if (i_ld_issue) pend_nxt[i_ld_issue_rd] = 1'b1;
    pend_nxt[0] = 1'b0;
  end
  // Payload storage needs no reset; validity is tracked by count alone.
  always_ff @(posedge i_clk)
    if (push) mem[wptr] <= '{i_lsu_rd, i_lsu_data, i_lsu_funct3, i_lsu_byteoff};
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      wptr <= '0;
      rptr <= '0;
      count <= '0;
      o_rd_wren <= 1'b0;
      o_rd_addr <= 5'd0;
      o_rd_data <= 32'd0;
      o_pending <= 32'd0;
    end else begin
      wptr <= wptr + AW'(push);
      rptr <= rptr + AW'(pop);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
      o_rd_wren <= alu_req || pop;
      o_rd_addr <= alu_req ? i_alu_rd : pop ? head.rd : o_rd_addr;
      o_rd_data <= alu_req ? i_alu_data : pop ? ext : o_rd_data;
      o_pending <= pend_nxt;
    end
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: table-driven cycle vectors plus a hand-written async reset sequence.
module tb_wb_arbiter;
  logic clk = 1'b0, rst_n = 1'b0;
  logic alu_v, lsu_v, lsu_rdy, iss, wren;
  logic [4:0] alu_rd, lsu_rd, iss_rd, addr;
  logic [31:0] alu_d, lsu_d, wdata, pend;
  logic [2:0] f3;
  logic [1:0] off, cnt;
  int total = 0, passed = 0;

  wb_arbiter #(.LSU_DEPTH(2)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_alu_valid(alu_v), .i_alu_rd(alu_rd), .i_alu_data(alu_d),
    .i_lsu_valid(lsu_v), .o_lsu_ready(lsu_rdy), .i_lsu_rd(lsu_rd), .i_lsu_data(lsu_d),
    .i_lsu_funct3(f3), .i_lsu_byteoff(off),
    .i_ld_issue(iss), .i_ld_issue_rd(iss_rd),
    .o_rd_wren(wren), .o_rd_addr(addr), .o_rd_data(wdata),
    .o_pending(pend), .o_lsu_count(cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        av; logic [4:0] ard; logic [31:0] ad;
    logic        lv; logic [4:0] lrd; logic [31:0] ld; logic [2:0] lf3; logic [1:0] loff;
    logic        iv; logic [4:0] ird;
    logic        ewren; logic [4:0] eaddr; logic [31:0] edata;
    logic        erdy; logic [1:0] ecnt; logic [31:0] epend;
  } vec_t;
  vec_t vq[$];

  task automatic add(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                     input logic lv, input logic [4:0] lrd, input logic [31:0] ld,
                     input logic [2:0] lf3, input logic [1:0] loff,
                     input logic iv, input logic [4:0] ird,
                     input logic ewren, input logic [4:0] eaddr, input logic [31:0] edata,
                     input logic erdy, input logic [1:0] ecnt, input logic [31:0] epend);
    vq.push_back('{av, ard, ad, lv, lrd, ld, lf3, loff, iv, ird, ewren, eaddr, edata, erdy, ecnt, epend});
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic chk_all(input string tag, input logic ew, input logic [4:0] ea, input logic [31:0] ed,
                         input logic er, input logic [1:0] ec, input logic [31:0] ep);
    chk({tag, " wren"}, 32'(wren), 32'(ew));
    chk({tag, " addr"}, 32'(addr), 32'(ea));
    chk({tag, " data"}, wdata, ed);
    chk({tag, " ready"}, 32'(lsu_rdy), 32'(er));
    chk({tag, " count"}, 32'(cnt), 32'(ec));
    chk({tag, " pending"}, pend, ep);
  endtask

  task automatic drive(input vec_t v);
    alu_v = v.av; alu_rd = v.ard; alu_d = v.ad;
    lsu_v = v.lv; lsu_rd = v.lrd; lsu_d = v.ld; f3 = v.lf3; off = v.loff;
    iss = v.iv; iss_rd = v.ird;
  endtask

  task automatic idle();
    vec_t z;
    z = '{1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 3'd0, 2'd0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0, 2'd0, 32'd0};
    drive(z);
  endtask

  initial begin
    //  alu          lsu                                  issue   | wren addr data         rdy cnt pend
    add(1, 5, 32'h1234, 0, 0, 0, 0, 0,                     0, 0,    1, 5, 32'h1234,     1, 0, 0);
    add(0, 0, 0,        0, 0, 0, 0, 0,                     0, 0,    0, 5, 32'h1234,     1, 0, 0);
    add(0, 0, 0,        1, 3, 32'h000080F0, 3'b000, 0,     0, 0,    0, 5, 32'h1234,     1, 1, 0);
    add(0, 0, 0,        0, 0, 0, 0, 0,                     0, 0,    1, 3, 32'hFFFFFFF0, 1, 0, 0);
    add(0, 0, 0,        1, 3, 32'h000080F0, 3'b100, 0,     0, 0,    0, 3, 32'hFFFFFFF0, 1, 1, 0);
    add(0, 0, 0,        1, 3, 32'h000080F0, 3'b001, 2,     0, 0,    1, 3, 32'h000000F0, 1, 1, 0);
    add(0, 0, 0,        0, 0, 0, 0, 0,                     0, 0,    1, 3, 32'h00000000, 1, 0, 0);
    add(0, 0, 0,        0, 0, 0, 0, 0,                     0, 0,    0, 3, 32'h00000000, 1, 0, 0);
    add(1, 1, 32'hA1,   1, 10, 32'h11111111, 3'b010, 0,    0, 0,    1, 1, 32'hA1,       1, 1, 0);
    add(1, 2, 32'hA2,   1, 11, 32'h22222222, 3'b010, 0,    0, 0,    1, 2, 32'hA2,       0, 2, 0);
    add(1, 3, 32'hA3,   1, 12, 32'h33333333, 3'b010, 0,    0, 0,    1, 3, 32'hA3,       0, 2, 0);
    add(1, 4, 32'hA4,   0, 0, 0, 0, 0,                     0, 0,    1, 4, 32'hA4,       0, 2, 0);
    add(0, 0, 0,        0, 0, 0, 0, 0,                     0, 0,    1, 10, 32'h11111111, 1, 1, 0);
    add(0, 0, 0,        0, 0, 0, 0, 0,                     0, 0,    1, 11, 32'h22222222, 1, 0, 0);
    add(0, 0, 0,        0, 0, 0, 0, 0,                     0, 0,    0, 11, 32'h22222222, 1, 0, 0);
    add(0, 0, 0,        1, 0, 32'hDEAD, 3'b010, 0,         0, 0,    0, 11, 32'h22222222, 1, 0, 0);
    add(1, 0, 32'hBEEF, 0, 0, 0, 0, 0,                     0, 0,    0, 11, 32'h22222222, 1, 0, 0);
    add(0, 0, 0,        0, 0, 0, 0, 0,                     1, 7,    0, 11, 32'h22222222, 1, 0, 32'h80);
    add(0, 0, 0,        1, 7, 32'h77, 3'b010, 0,           0, 0,    0, 11, 32'h22222222, 1, 1, 32'h80);
    add(0, 0, 0,        0, 0, 0, 0, 0,                     0, 0,    1, 7, 32'h77,       1, 0, 0);
    add(0, 0, 0,        1, 7, 32'h78, 3'b010, 0,           1, 7,    0, 7, 32'h77,       1, 1, 32'h80);
    add(0, 0, 0,        0, 0, 0, 0, 0,                     1, 7,    1, 7, 32'h78,       1, 0, 32'h80);
    add(1, 7, 32'h99,   0, 0, 0, 0, 0,                     0, 0,    1, 7, 32'h99,       1, 0, 32'h80);
    add(0, 0, 0,        0, 0, 0, 0, 0,                     1, 0,    0, 7, 32'h99,       1, 0, 32'h80);
    add(0, 0, 0,        0, 0, 0, 0, 0,                     1, 31,   0, 7, 32'h99,       1, 0, 32'h80000080);
    add(0, 0, 0,        1, 9, 32'h80010000, 3'b001, 2,     0, 0,    0, 7, 32'h99,       1, 1, 32'h80000080);
    add(0, 0, 0,        1, 9, 32'h0000AB00, 3'b000, 1,     0, 0,    1, 9, 32'hFFFF8001, 1, 1, 32'h80000080);
    add(0, 0, 0,        1, 9, 32'h12345678, 3'b101, 2,     0, 0,    1, 9, 32'hFFFFFFAB, 1, 1, 32'h80000080);
    add(0, 0, 0,        1, 9, 32'hCAFEBABE, 3'b011, 0,     0, 0,    1, 9, 32'h00001234, 1, 1, 32'h80000080);
    add(0, 0, 0,        0, 0, 0, 0, 0,                     0, 0,    1, 9, 32'hCAFEBABE, 1, 0, 32'h80000080);

    idle();
    #12;
    chk_all("reset", 0, 0, 0, 1, 0, 0);
    rst_n = 1'b1;
    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i]);
      @(posedge clk);
      #1;
      chk_all($sformatf("vec%0d", i), vq[i].ewren, vq[i].eaddr, vq[i].edata, vq[i].erdy, vq[i].ecnt, vq[i].epend);
    end

    // fill the FIFO behind a busy ALU, then reset between clock edges
    alu_v = 1; alu_rd = 1; alu_d = 32'h55;
    lsu_v = 1; lsu_rd = 20; lsu_d = 32'h20; f3 = 3'b010; off = 0;
    iss = 1; iss_rd = 20;
    @(posedge clk); #1;
    lsu_rd = 21; iss_rd = 21;
    @(posedge clk); #1;
    chk_all("full", 1, 1, 32'h55, 0, 2, 32'h80300080);
    idle();
    #2 rst_n = 1'b0;
    #1 chk_all("async_rst", 0, 0, 0, 1, 0, 0);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk_all("post_rst1", 0, 0, 0, 1, 0, 0);
    @(posedge clk); #1;
    chk_all("post_rst2", 0, 0, 0, 1, 0, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have parameter LSU_DEPTH, default 2, LSU result FIFO depth (power of two, >=2).
REQ-002 SHALL have port i_clk  input  1  clock; all state updates on posedge.
REQ-003 SHALL have port i_rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port i_alu_valid  input  1  ALU result valid this cycle (no backpressure).
REQ-005 SHALL have ports i_alu_rd  input  5  and i_alu_data  input  32: ALU destination and result.
REQ-006 SHALL have port i_lsu_valid  input  1  and o_lsu_ready  output  1: load-result handshake.
REQ-007 SHALL have ports i_lsu_rd  input  5, i_lsu_data  input  32 (raw aligned word), i_lsu_funct3  input  3, i_lsu_byteoff  input  2.
REQ-008 SHALL have ports i_ld_issue  input  1  and i_ld_issue_rd  input  5: load issued to LSU.
REQ-009 SHALL have ports o_rd_wren  output  1, o_rd_addr  output  5, o_rd_data  output  32: register-file write port.
REQ-010 SHALL have port o_pending  output  32  per-register outstanding-load scoreboard.
REQ-011 SHALL have port o_lsu_count  output  $clog2(LSU_DEPTH)+1  FIFO occupancy.

Function
REQ-012 SHALL accept an LSU result when i_lsu_valid && o_lsu_ready at posedge.
REQ-013 SHALL drive o_lsu_ready = (o_lsu_count < LSU_DEPTH) from registered state only; no same-cycle credit from a pop.
REQ-014 SHALL discard accepted LSU results with i_lsu_rd==0 (handshake completes, nothing enqueued).
REQ-015 SHALL treat i_alu_valid with i_alu_rd==0 as no request.
REQ-016 SHALL register outputs: a write selected in cycle N appears on o_rd_* during cycle N+1 (latency 1).
REQ-017 SHALL give ALU strict priority; FIFO head pops only in cycles with no ALU request.
REQ-018 SHALL drive o_rd_wren=0 and hold o_rd_addr/o_rd_data at their previous values in cycles with no selected write.
REQ-019 SHALL accept a push into an empty FIFO that is not eligible to pop until the following cycle.
REQ-020 SHALL allow push and pop in the same cycle when not full; count unchanged.
REQ-021 SHALL extend popped load data by funct3: 000 LB sign-ext byte[off]; 001 LH sign-ext half[off[1]]; 010 LW word; 100 LBU zero-ext byte; 101 LHU zero-ext half; others pass raw word.
REQ-022 SHALL set o_pending[rd] on i_ld_issue with rd!=0; bit 0 never set.
REQ-023 SHALL clear o_pending[rd] when an LSU pop for rd is selected (same edge as o_rd_wren capture).
REQ-024 SHALL let set win over clear when issue and pop target the same rd in one cycle.
REQ-025 SHALL not clear o_pending on ALU writes to the same rd.
REQ-026 SHALL keep FIFO pointers wrapping modulo LSU_DEPTH with separate occupancy count (no ambiguity at full).

Reset
REQ-027 SHALL on i_rst_n low immediately clear FIFO count/pointers, o_pending=0, o_rd_wren=0, o_rd_addr=0, o_rd_data=0, o_lsu_count=0.
REQ-028 SHALL drive o_lsu_ready=1 after reset (count 0); reset mid-transfer discards all queued results.

Verification
REQ-029 SHALL verify: ALU rd=5 data 0x1234 at cycle 0 -> o_rd_wren=1, addr 5, data 0x1234 in cycle 1.
REQ-030 SHALL verify: LSU push rd=3 data 0x000080F0 funct3=000 off=0 -> writes 0xFFFFFFF0; same with funct3=100 -> 0x000000F0; funct3=001 off=2 -> 0x00000000.
REQ-031 SHALL verify: continuous ALU writes for 4 cycles with 2 LSU pushes -> o_lsu_ready=0 after 2nd push, LSU writes appear in order only after ALU stream stops.
REQ-032 SHALL verify: i_ld_issue rd=7 -> o_pending[7]=1 next cycle; LSU pop rd=7 -> bit cleared same cycle o_rd_wren captured; simultaneous reissue rd=7 keeps bit 1.
REQ-033 SHALL verify: LSU push with rd=0 -> handshake completes, o_lsu_count unchanged, no write.
REQ-034 SHALL verify: i_rst_n asserted with FIFO full and pending bits set -> all outputs zero, o_lsu_ready=1 without waiting for clock.
